// File: rtl/time_display.sv
// Stopwatch display back-end: converts {minutes, seconds} to BCD with a
// sequential shift-add-3 engine and scans a 4-digit MM.SS seven-segment display.
module time_display #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [11:0] time_in,
    input  logic        blank,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        busy
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q;
    logic [11:0]      last_q;
    logic [5:0]       min_bin_q, sec_bin_q;
    logic [7:0]       min_bcd_q, sec_bcd_q;
    logic [2:0]       bit_cnt_q;
    logic [3:0][3:0]  dig_q;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       scan_idx_q, scan_idx_d;
    logic [13:0]      min_sh, sec_sh;
    logic [3:0]       cur_dig;

    function automatic logic [7:0] add3(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b[3:0] >= 4'd5) r[3:0] = b[3:0] + 4'd3;
        if (b[7:4] >= 4'd5) r[7:4] = b[7:4] + 4'd3;
        return r;
    endfunction

    function automatic logic [6:0] seg_pat(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // One double-dabble iteration: adjust nibbles, then shift {bcd, bin} left.
    assign min_sh = {add3(min_bcd_q), min_bin_q} << 1;
    assign sec_sh = {add3(sec_bcd_q), sec_bin_q} << 1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            last_q    <= '0;
            min_bin_q <= '0;
            sec_bin_q <= '0;
            min_bcd_q <= '0;
            sec_bcd_q <= '0;
            bit_cnt_q <= '0;
            dig_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (time_in != last_q) begin
                        last_q    <= time_in;
                        min_bin_q <= time_in[11:6];
                        sec_bin_q <= time_in[5:0];
                        min_bcd_q <= '0;
                        sec_bcd_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    min_bcd_q <= min_sh[13:6];
                    min_bin_q <= min_sh[5:0];
                    sec_bcd_q <= sec_sh[13:6];
                    sec_bin_q <= sec_sh[5:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd5) state_q <= DONE;
                end
                DONE: begin
                    // All four digits land together so the scan never shows a mix.
                    dig_q   <= {min_bcd_q[7:4], min_bcd_q[3:0], sec_bcd_q[7:4], sec_bcd_q[3:0]};
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == CNT_MAX) begin
            scan_cnt_d = '0;
            scan_idx_d = scan_idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    assign cur_dig = dig_q[scan_idx_q];
    assign busy    = (state_q != IDLE);

    always_comb begin
        seg = 7'h00;
        an  = 4'b0000;
        dp  = 1'b0;
        if (!blank) begin
            seg = seg_pat(cur_dig);
            an  = 4'b0001 << scan_idx_q;
            dp  = (scan_idx_q == 2'd2);
        end
    end

endmodule

// File: tb/tb_time_display.sv
// Directed bench for time_display with a fast scan (SCAN_DIV = 4).
module tb_time_display;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic [11:0] time_in;
    logic        blank;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    time_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .time_in (time_in),
        .blank   (blank),
        .seg     (seg),
        .an      (an),
        .dp      (dp),
        .busy    (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [3:0] a);
        case (a)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    // Samples 16 consecutive cycles and records what each digit slot displayed.
    task automatic scan_capture(output logic [3:0][6:0] segs, output logic [3:0] dps,
                                output logic [3:0] seen);
        segs = '0;
        dps  = '0;
        seen = '0;
        for (int k = 0; k < 16; k++) begin
            step();
            case (an)
                4'b0001: begin segs[0] = seg; dps[0] = dp; seen[0] = 1'b1; end
                4'b0010: begin segs[1] = seg; dps[1] = dp; seen[1] = 1'b1; end
                4'b0100: begin segs[2] = seg; dps[2] = dp; seen[2] = 1'b1; end
                4'b1000: begin segs[3] = seg; dps[3] = dp; seen[3] = 1'b1; end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        nrst    = 1'b0;
        time_in = 12'd0;
        blank   = 1'b0;
        #2;
        n_checks++;
        if ({seg, an, dp, busy} !== {7'h3F, 4'b0001, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_out: got seg=%h an=%b dp=%b busy=%b, expected seg=3f an=0001 dp=0 busy=0",
                     seg, an, dp, busy);
        end
        repeat (3) step();
        nrst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_checks++;
            if ({busy, seg, an, dp} !== {1'b0, 7'h3F, 4'b0001 << (k / 4), (k / 4) == 2}) begin
                n_fail++;
                $display("FAIL reset_idle%0d: got busy=%b seg=%h an=%b dp=%b, expected busy=0 seg=3f an=%b",
                         k, busy, seg, an, dp, 4'b0001 << (k / 4));
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0][6:0] exp_seg;
        logic [3:0] prev;
        bit found;
        exp_seg = {7'h06, 7'h5B, 7'h4F, 7'h66};
        time_in = {6'd12, 6'd34};
        for (int k = 1; k <= 7; k++) begin
            step();
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_busy%0d: got %b expected 1", k, busy);
            end
        end
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_end: got %b expected 0", busy);
        end
        prev  = an;
        found = 1'b0;
        for (int k = 0; k < 24 && !found; k++) begin
            step();
            if (an == 4'b0001 && prev == 4'b1000) found = 1'b1;
            prev = an;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL basic_scan_sync: got no 1000->0001 transition, expected one within 24 cycles");
        end else begin
            for (int k = 0; k < 16; k++) begin
                n_checks++;
                if ({an, seg, dp} !== {4'b0001 << (k / 4), exp_seg[k / 4], (k / 4) == 2}) begin
                    n_fail++;
                    $display("FAIL basic_scan%0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                             k, an, seg, dp, 4'b0001 << (k / 4), exp_seg[k / 4], (k / 4) == 2);
                end
                step();
            end
        end
    endtask

    task automatic test_range();
        logic [3:0][6:0] exp_seg, segs;
        logic [3:0] dps, seen;
        exp_seg = {7'h7D, 7'h4F, 7'h7D, 7'h3F};
        time_in = {6'd63, 6'd60};
        repeat (8) step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL range_busy_end: got %b expected 0", busy);
        end
        scan_capture(segs, dps, seen);
        n_checks++;
        if (seen !== 4'hF || dps !== 4'b0100) begin
            n_fail++;
            $display("FAIL range_scan: got seen=%b dp=%b, expected seen=1111 dp=0100", seen, dps);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (segs[i] !== exp_seg[i]) begin
                n_fail++;
                $display("FAIL range_seg%0d: got %h expected %h", i, segs[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_mid_change();
        logic [3:0][6:0] exp_seg, segs;
        logic [3:0] dps, seen;
        int idx;
        exp_seg = {7'h3F, 7'h3F, 7'h6D, 7'h6F};
        time_in = {6'd0, 6'd5};
        repeat (3) step();
        time_in = {6'd0, 6'd59};
        repeat (4) step();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy7: got %b expected 1", busy);
        end
        for (int e = 8; e <= 16; e++) begin
            if (e > 8) step();
            else step();
            n_checks++;
            if (busy !== ((e == 8 || e == 16) ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL mid_busy%0d: got %b expected %b", e, busy, (e == 8 || e == 16) ? 1'b0 : 1'b1);
            end
            if (e < 16) begin
                idx = idx_of(an);
                n_checks++;
                if (idx < 0 || seg !== ((idx == 0) ? 7'h6D : 7'h3F)) begin
                    n_fail++;
                    $display("FAIL mid_first%0d: got an=%b seg=%h, expected digits 0,0,0,5", e, an, seg);
                end
            end
        end
        scan_capture(segs, dps, seen);
        n_checks++;
        if (seen !== 4'hF) begin
            n_fail++;
            $display("FAIL mid_scan: got seen=%b expected 1111", seen);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (segs[i] !== exp_seg[i]) begin
                n_fail++;
                $display("FAIL mid_seg%0d: got %h expected %h", i, segs[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_blank();
        logic [3:0][6:0] exp_seg, segs;
        logic [3:0] dps, seen, prev;
        int i0;
        bit found;
        exp_seg = {7'h66, 7'h6D, 7'h06, 7'h7F};
        prev  = an;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            step();
            if (an != prev) found = 1'b1;
            prev = an;
        end
        i0 = idx_of(an);
        n_checks++;
        if (!found || i0 < 0) begin
            n_fail++;
            $display("FAIL blank_sync: got an=%b, expected a one-hot digit change within 8 cycles", an);
            i0 = 0;
        end
        blank   = 1'b1;
        time_in = {6'd45, 6'd18};
        #1;
        n_checks++;
        if ({seg, an, dp} !== 12'd0) begin
            n_fail++;
            $display("FAIL blank_now: got seg=%h an=%b dp=%b expected all 0", seg, an, dp);
        end
        for (int k = 1; k <= 10; k++) begin
            step();
            n_checks++;
            if ({seg, an, dp} !== 12'd0 || (k == 1 && busy !== 1'b1)) begin
                n_fail++;
                $display("FAIL blank_hold%0d: got seg=%h an=%b dp=%b busy=%b expected dark display",
                         k, seg, an, dp, busy);
            end
        end
        blank = 1'b0;
        #1;
        n_checks++;
        if ({an, seg, busy} !== {4'b0001 << ((i0 + 2) % 4), exp_seg[(i0 + 2) % 4], 1'b0}) begin
            n_fail++;
            $display("FAIL blank_release: got an=%b seg=%h busy=%b expected an=%b seg=%h busy=0",
                     an, seg, busy, 4'b0001 << ((i0 + 2) % 4), exp_seg[(i0 + 2) % 4]);
        end
        scan_capture(segs, dps, seen);
        n_checks++;
        if (seen !== 4'hF || dps !== 4'b0100) begin
            n_fail++;
            $display("FAIL blank_scan: got seen=%b dp=%b, expected seen=1111 dp=0100", seen, dps);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (segs[i] !== exp_seg[i]) begin
                n_fail++;
                $display("FAIL blank_seg%0d: got %h expected %h", i, segs[i], exp_seg[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0][6:0] exp_seg, segs;
        logic [3:0] dps, seen;
        exp_seg = {7'h3F, 7'h07, 7'h3F, 7'h07};
        time_in = {6'd7, 6'd7};
        repeat (3) step();
        nrst = 1'b0;
        #1;
        n_checks++;
        if ({seg, an, dp, busy} !== {7'h3F, 4'b0001, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rmid_out: got seg=%h an=%b dp=%b busy=%b, expected seg=3f an=0001 dp=0 busy=0",
                     seg, an, dp, busy);
        end
        repeat (2) step();
        nrst = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_checks++;
            if (busy !== (e < 8)) begin
                n_fail++;
                $display("FAIL rmid_busy%0d: got %b expected %b", e, busy, e < 8);
            end
        end
        scan_capture(segs, dps, seen);
        n_checks++;
        if (seen !== 4'hF || dps !== 4'b0100) begin
            n_fail++;
            $display("FAIL rmid_scan: got seen=%b dp=%b, expected seen=1111 dp=0100", seen, dps);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (segs[i] !== exp_seg[i]) begin
                n_fail++;
                $display("FAIL rmid_seg%0d: got %h expected %h", i, segs[i], exp_seg[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
        test_mid_change();
        test_blank();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
